inst_queue: RTL and testbench

Instruction queue between decoder and dispatcher. It buffers up to DEPTH decoded packets in program order, so fetch and decode keep running while the dispatcher holds its input on a full reservation station. The queue presents the oldest packet to the dispatcher every cycle and retires it on any cycle the dispatcher does not stall. ROB flush (mispredict) squashes all buffered packets.

---
 rtl/inst_queue.sv | 82 ++++++++
 tb/tb_inst_queue.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Decoded-packet FIFO between decoder and dispatcher; head retires whenever the dispatcher is not stalled.
// Enqueue-to-head latency 1 cycle, no bypass; upstream is backpressured by full, flush squashes all entries.
package inst_queue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } decoded_pack_t;
endpackage

module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    input  decoded_pack_t        in_pack,
    input  logic                 dispatch_stall,
    output logic                 out_valid,
    output decoded_pack_t        out_pack,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_W-1:0]     count,
    output logic                 overflow_err
);
    localparam int PTR_W = $clog2(DEPTH);

    decoded_pack_t    mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic             enq;
    logic             deq;

    // Status is decoded from the registered count only, so no input reaches an output combinationally.
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign out_valid = !empty;
    assign out_pack  = empty ? '0 : mem[head_ptr];

    // full is the pre-dequeue value: a full queue rejects even when the head retires this cycle.
    assign enq = in_valid && !full && !flush;
    assign deq = out_valid && !dispatch_stall && !flush;

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail_ptr] <= in_pack;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr     <= '0;
            tail_ptr     <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (in_valid && full) begin
                overflow_err <= 1'b1;
            end
            if (flush) begin
                head_ptr <= '0;
                tail_ptr <= '0;
                count    <= '0;
            end else begin
                if (enq) begin
                    tail_ptr <= tail_ptr + 1'b1;
                end
                if (deq) begin
                    head_ptr <= head_ptr + 1'b1;
                end
                count <= count + CNT_W'(enq) - CNT_W'(deq);
            end
        end
    end
endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: vector table plus scoreboard of expected head packets, and hand sequences for corner cases.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    decoded_pack_t     in_pack;
    logic              dispatch_stall;
    logic              out_valid;
    decoded_pack_t     out_pack;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow_err;

    inst_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_pack        (in_pack),
        .dispatch_stall (dispatch_stall),
        .out_valid      (out_valid),
        .out_pack       (out_pack),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .overflow_err   (overflow_err)
    );

    always #5 clk = ~clk;

    int            n_pass  = 0;
    int            n_total = 0;
    decoded_pack_t sb_q[$];
    bit            ovf_m   = 1'b0;

    typedef struct {
        bit          f;
        bit          v;
        logic [31:0] pc;
        bit          st;
        int          cnt;
        bit          full;
        bit          ovf;
        logic [31:0] head;
    } vec_t;

    vec_t vecs[10];

    function automatic decoded_pack_t mk(input logic [31:0] pc);
        decoded_pack_t p;
        p.pc     = pc;
        p.inst   = pc ^ 32'hA5A5_0F0F;
        p.opcode = pc[8:2];
        p.rd     = pc[6:2];
        p.rs1    = ~pc[6:2];
        p.rs2    = pc[10:6];
        return p;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_state();
        decoded_pack_t head_exp;
        head_exp = (sb_q.size() > 0) ? sb_q[0] : '0;
        chk("count", 128'(count), 128'(sb_q.size()));
        chk("full", 128'(full), 128'(sb_q.size() == DEPTH));
        chk("empty", 128'(empty), 128'(sb_q.size() == 0));
        chk("out_valid", 128'(out_valid), 128'(sb_q.size() > 0));
        chk("out_pack", 128'(out_pack), 128'(head_exp));
        chk("overflow_err", 128'(overflow_err), 128'(ovf_m));
    endtask

    // Drive one cycle, retire the expected head from the scoreboard on a dequeue, then check post-edge state.
    task automatic step(input bit f, input bit v, input logic [31:0] pc, input bit st);
        decoded_pack_t exp_p;
        bit fm, enq, deq;
        @(negedge clk);
        flush = f; in_valid = v; in_pack = mk(pc); dispatch_stall = st;
        fm  = (sb_q.size() == DEPTH);
        enq = v && !fm && !f;
        deq = (sb_q.size() > 0) && !st && !f;
        if (deq) begin
            exp_p = sb_q.pop_front();
            chk("deq_order", 128'(out_pack), 128'(exp_p));
        end
        if (v && fm) ovf_m = 1'b1;
        if (f) sb_q.delete();
        if (enq) sb_q.push_back(mk(pc));
        @(posedge clk);
        #1;
        check_state();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pack = '0; dispatch_stall = 1'b0;
        for (int i = 0; i < 8; i++)
            vecs[i] = '{f:0, v:1, pc:32'(4 * i), st:1, cnt:i + 1, full:(i == 7), ovf:0, head:32'h0};
        vecs[8] = '{f:0, v:1, pc:32'h20, st:0, cnt:7, full:0, ovf:1, head:32'h4};
        vecs[9] = '{f:0, v:1, pc:32'h20, st:1, cnt:8, full:1, ovf:1, head:32'h4};

        #2;
        check_state();
        @(negedge clk);
        reset = 1'b0;

        // Fill to full, then the reject-while-dequeuing cycle and its retry.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].f, vecs[i].v, vecs[i].pc, vecs[i].st);
            chk("vec_count", 128'(count), 128'(vecs[i].cnt));
            chk("vec_full", 128'(full), 128'(vecs[i].full));
            chk("vec_ovf", 128'(overflow_err), 128'(vecs[i].ovf));
            chk("vec_head_pc", 128'(out_pack.pc), 128'(vecs[i].head));
        end

        for (int i = 0; i < 8; i++) step(0, 0, 32'h0, 0);

        // Empty queue: no same-cycle bypass, head visible one edge later.
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b1; in_pack = mk(32'h100); dispatch_stall = 1'b0;
        #1;
        chk("nobypass_valid", 128'(out_valid), 128'(0));
        chk("nobypass_pack", 128'(out_pack), 128'(0));
        sb_q.push_back(mk(32'h100));
        @(posedge clk);
        #1;
        check_state();
        chk("bypass_head_pc", 128'(out_pack.pc), 128'(32'h100));
        step(0, 0, 32'h0, 0);

        // Streaming through both pointer wraps.
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 32'h200 + 32'(4 * i), 0);
            chk("stream_count", 128'(count), 128'(1));
        end
        step(0, 0, 32'h0, 0);

        // Flush with a simultaneous offered packet and unstalled dispatcher.
        for (int i = 0; i < 5; i++) step(0, 1, 32'h400 + 32'(4 * i), 1);
        step(1, 1, 32'h500, 0);
        chk("flush_count", 128'(count), 128'(0));
        step(0, 0, 32'h0, 0);

        // Asynchronous reset mid-cycle with six entries and a sticky overflow.
        for (int i = 0; i < 6; i++) step(0, 1, 32'h600 + 32'(4 * i), 1);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_count", 128'(count), 128'(0));
        chk("arst_empty", 128'(empty), 128'(1));
        chk("arst_full", 128'(full), 128'(0));
        chk("arst_valid", 128'(out_valid), 128'(0));
        chk("arst_pack", 128'(out_pack), 128'(0));
        chk("arst_ovf", 128'(overflow_err), 128'(0));
        sb_q.delete();
        ovf_m = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step(0, 1, 32'h300, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
